hp48_bus_master: RTL and testbench

//  Bus initiator for the HP48 nibble bus; the counterpart of the memory/MMIO responders.

---
 rtl/hp48_bus_master_pkg.sv | 63 ++++++
 rtl/hp48_bus_nib_shifter.sv | 42 ++++
 rtl/hp48_bus_master.sv | 266 ++++++++++++++++++++++++++
 tb/tb_hp48_bus_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp48_bus_master_pkg.sv
// Shared definitions for the HP48 nibble-bus master.
//  - BUSCMD_* : command codes driven on bus_command (BUSCMD_NOP = idle cycle)
//  - OP_*     : CPU-side request encodings on req_op
//  - state_t  : master FSM states, also visible on the debug_state output
//  - helpers mapping a request op to its pointer-load and transfer commands
package hp48_bus_master_pkg;

    localparam logic [3:0] BUSCMD_PC_READ     = 4'h0;
    localparam logic [3:0] BUSCMD_DP_WRITE    = 4'h1;
    localparam logic [3:0] BUSCMD_DP_READ     = 4'h2;
    localparam logic [3:0] BUSCMD_PC_WRITE    = 4'h3;
    localparam logic [3:0] BUSCMD_LOAD_PC     = 4'h4;
    localparam logic [3:0] BUSCMD_LOAD_DP     = 4'h5;
    localparam logic [3:0] BUSCMD_CONFIGURE   = 4'h6;
    localparam logic [3:0] BUSCMD_UNCONFIGURE = 4'h7;
    localparam logic [3:0] BUSCMD_POLL        = 4'h8;
    localparam logic [3:0] BUSCMD_RESET       = 4'h9;
    // Responders treat NOP as "nothing this cycle" and never flag it.
    localparam logic [3:0] BUSCMD_NOP         = 4'hF;

    localparam logic [2:0] OP_READ_PC   = 3'd0;
    localparam logic [2:0] OP_READ_DP   = 3'd1;
    localparam logic [2:0] OP_WRITE_DP  = 3'd2;
    localparam logic [2:0] OP_CONFIGURE = 3'd3;
    localparam logic [2:0] OP_BUS_RESET = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_CFG   = 3'd5,
        ST_BRST  = 3'd6
    } state_t;

    function automatic logic op_is_xfer(input logic [2:0] op);
        return (op == OP_READ_PC) || (op == OP_READ_DP) || (op == OP_WRITE_DP);
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_READ_PC) || (op == OP_READ_DP);
    endfunction

    function automatic logic op_is_known(input logic [2:0] op);
        return op <= OP_BUS_RESET;
    endfunction

    function automatic logic [3:0] load_cmd_for(input logic [2:0] op);
        return (op == OP_READ_PC) ? BUSCMD_LOAD_PC : BUSCMD_LOAD_DP;
    endfunction

    function automatic logic [3:0] xfer_cmd_for(input logic [2:0] op);
        logic [3:0] cmd;
        case (op)
            OP_READ_PC: cmd = BUSCMD_PC_READ;
            OP_READ_DP: cmd = BUSCMD_DP_READ;
            default:    cmd = BUSCMD_DP_WRITE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/hp48_bus_nib_shifter.sv
// Nibble steering for burst data.
//  Read side : rdata_next is rdata_cur with nibble rd_idx replaced by nib_in.
//  Write side: wr_nib is nibble wr_idx of wdata.
// Ports:
//  rdata_cur  in  4*MAX_NIBS  read data assembled so far
//  rd_idx     in  4           nibble slot to fill
//  nib_in     in  4           nibble captured from the bus
//  rdata_next out 4*MAX_NIBS  updated read data
//  wdata      in  4*MAX_NIBS  latched write data
//  wr_idx     in  4           nibble slot to send
//  wr_nib     out 4           selected write nibble (0 if wr_idx is beyond MAX_NIBS)
module hp48_bus_nib_shifter #(
    parameter int MAX_NIBS = 16
) (
    input  logic [4*MAX_NIBS-1:0] rdata_cur,
    input  logic [3:0]            rd_idx,
    input  logic [3:0]            nib_in,
    output logic [4*MAX_NIBS-1:0] rdata_next,
    input  logic [4*MAX_NIBS-1:0] wdata,
    input  logic [3:0]            wr_idx,
    output logic [3:0]            wr_nib
);

    always_comb begin
        rdata_next = rdata_cur;
        for (int i = 0; i < MAX_NIBS; i++) begin
            if (rd_idx == 4'(i)) begin
                rdata_next[4*i +: 4] = nib_in;
            end
        end
    end

    always_comb begin
        wr_nib = 4'h0;
        for (int i = 0; i < MAX_NIBS; i++) begin
            if (wr_idx == 4'(i)) begin
                wr_nib = wdata[4*i +: 4];
            end
        end
    end

endmodule

// File: rtl/hp48_bus_master.sv
// HP48 nibble-bus initiator. Takes one CPU request at a time and turns it
// into bus commands, one per strobe: pointer load + READ/WRITE burst,
// CONFIGURE, or bus RESET. Read nibbles are reassembled into resp_rdata and
// any transfer cycle that no responder claims (or that raises bus_error)
// sets resp_error.
//
// Handshake: a request is taken on a strobe edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE, so at most one request
// is in flight and req_valid is ignored while busy. Completion is a single
// cycle resp_valid pulse with resp_rdata/resp_error valid in that cycle.
//
// Optional build macro HP48_BUS_PTR_CACHE_EN: keep shadows of the responders'
// PC/DP pointers and skip the pointer load when the request starts exactly
// where the previous burst on that pointer ended.
//
// Ports:
//  strobe          in   bus clock, rising edge
//  reset           in   asynchronous active-high reset
//  req_valid/ready      request handshake
//  req_op/addr/len/wdata request fields (len = nibbles - 1, nibble 0 in [3:0])
//  resp_valid      out  completion pulse
//  resp_rdata      out  read nibbles, unused upper nibbles 0
//  resp_error      out  unclaimed access or bus_error during the burst
//  bus_command     out  BUSCMD_* to responders (NOP when idle)
//  bus_address     out  address for LOAD_PC/LOAD_DP/CONFIGURE, else 0
//  bus_nibble_out  out  write nibble during DP_WRITE, else 0
//  bus_nibble_in   in   OR of responder read nibbles (registered by responders)
//  bus_active      in   OR of responder claim flags
//  bus_error       in   OR of responder error flags
//  daisy_out       out  daisy chain enable to the first responder
//  debug_state     out  current FSM state
module hp48_bus_master
    import hp48_bus_master_pkg::*;
#(
    parameter int MAX_NIBS = 16
) (
    input  logic                  strobe,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [19:0]           req_addr,
    input  logic [3:0]            req_len,
    input  logic [4*MAX_NIBS-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [4*MAX_NIBS-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [3:0]            bus_command,
    output logic [19:0]           bus_address,
    output logic [3:0]            bus_nibble_out,
    input  logic [3:0]            bus_nibble_in,
    input  logic                  bus_active,
    input  logic                  bus_error,
    output logic                  daisy_out,
    output state_t                debug_state
);

    state_t                state_q, state_d;
    logic [2:0]            op_q;
    logic [19:0]           addr_q;
    logic [3:0]            len_q;
    logic [4*MAX_NIBS-1:0] wdata_q;
    logic [4*MAX_NIBS-1:0] rdata_q;
    logic                  err_q;
    logic [3:0]            n_q;
    logic                  daisy_q;

    logic                  last_xfer;
    logic                  is_read;
    logic                  ptr_hit;
    logic                  cap_en;
    logic [3:0]            cap_idx;
    logic [4*MAX_NIBS-1:0] rdata_next;
    logic [3:0]            wr_nib;

    assign last_xfer = (n_q == len_q);
    assign is_read   = op_is_read(op_q);

    // Responders register read data on the command edge, so the nibble for
    // command i is on bus_nibble_in during cycle i+1. XFER cycles after the
    // first capture the previous command's nibble; DRAIN captures the last.
    assign cap_en  = is_read && (n_q != 4'd0);
    assign cap_idx = (state_q == ST_DRAIN) ? n_q : (n_q - 4'd1);

    hp48_bus_nib_shifter #(
        .MAX_NIBS (MAX_NIBS)
    ) u_nib_shifter (
        .rdata_cur  (rdata_q),
        .rd_idx     (cap_idx),
        .nib_in     (bus_nibble_in),
        .rdata_next (rdata_next),
        .wdata      (wdata_q),
        .wr_idx     (n_q),
        .wr_nib     (wr_nib)
    );

`ifdef HP48_BUS_PTR_CACHE_EN
    logic [19:0] pc_shadow, dp_shadow;
    logic        pc_shadow_valid, dp_shadow_valid;
    logic [19:0] burst_end;

    // Responder pointers advance once per transfer and wrap at 20 bits.
    assign burst_end = addr_q + {16'd0, len_q} + 20'd1;

    always_comb begin
        ptr_hit = 1'b0;
        if (req_op == OP_READ_PC) begin
            ptr_hit = pc_shadow_valid && (pc_shadow == req_addr);
        end else if ((req_op == OP_READ_DP) || (req_op == OP_WRITE_DP)) begin
            ptr_hit = dp_shadow_valid && (dp_shadow == req_addr);
        end
    end

    always_ff @(posedge strobe or posedge reset) begin
        if (reset) begin
            pc_shadow       <= '0;
            dp_shadow       <= '0;
            pc_shadow_valid <= 1'b0;
            dp_shadow_valid <= 1'b0;
        end else begin
            case (state_q)
                ST_XFER: begin
                    if (last_xfer) begin
                        if (op_q == OP_READ_PC) begin
                            pc_shadow       <= burst_end;
                            pc_shadow_valid <= 1'b1;
                        end else begin
                            dp_shadow       <= burst_end;
                            dp_shadow_valid <= 1'b1;
                        end
                    end
                end
                // Responders may be re-mapped or reset: pointers unknown.
                ST_CFG, ST_BRST: begin
                    pc_shadow_valid <= 1'b0;
                    dp_shadow_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`else
    assign ptr_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge strobe or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus outputs
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        bus_command    = BUSCMD_NOP;
        bus_address    = '0;
        bus_nibble_out = 4'h0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (op_is_xfer(req_op)) begin
                        state_d = ptr_hit ? ST_XFER : ST_LOAD;
                    end else if (req_op == OP_CONFIGURE) begin
                        state_d = ST_CFG;
                    end else if (req_op == OP_BUS_RESET) begin
                        state_d = ST_BRST;
                    end else begin
                        // Unknown op: complete at once with error so the
                        // requester is never left waiting.
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                bus_command = load_cmd_for(op_q);
                bus_address = addr_q;
                state_d     = ST_XFER;
            end
            ST_XFER: begin
                bus_command = xfer_cmd_for(op_q);
                if (!is_read) begin
                    bus_nibble_out = wr_nib;
                end
                if (last_xfer) begin
                    state_d = is_read ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_CFG: begin
                bus_command = BUSCMD_CONFIGURE;
                bus_address = addr_q;
                state_d     = ST_DONE;
            end
            ST_BRST: begin
                bus_command = BUSCMD_RESET;
                state_d     = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latches, read assembly, sticky error, nibble counter
    always_ff @(posedge strobe or posedge reset) begin
        if (reset) begin
            op_q    <= OP_READ_PC;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            n_q     <= '0;
            daisy_q <= 1'b0;
        end else begin
            daisy_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        len_q   <= req_len;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= !op_is_known(req_op);
                        n_q     <= '0;
                    end
                end
                ST_XFER: begin
                    if (!bus_active || bus_error) begin
                        err_q <= 1'b1;
                    end
                    if (cap_en) begin
                        rdata_q <= rdata_next;
                    end
                    // Holding at len keeps a 16-nibble burst from wrapping n.
                    if (!last_xfer) begin
                        n_q <= n_q + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    rdata_q <= rdata_next;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata  = rdata_q;
    assign resp_error  = err_q;
    assign daisy_out   = daisy_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_hp48_bus_master.sv
module tb_hp48_bus_master;
  import hp48_bus_master_pkg::*;

`ifdef HP48_BUS_PTR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        strobe, reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [19:0] req_addr;
  logic [3:0]  req_len;
  logic [63:0] req_wdata;
  logic        resp_valid, resp_error;
  logic [63:0] resp_rdata;
  logic [3:0]  bus_command, bus_nibble_out, bus_nibble_in;
  logic [19:0] bus_address;
  logic        bus_active, bus_error, daisy_out;
  state_t      dbg_state;

  hp48_bus_master dut (
    .strobe         (strobe),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .bus_command    (bus_command),
    .bus_address    (bus_address),
    .bus_nibble_out (bus_nibble_out),
    .bus_nibble_in  (bus_nibble_in),
    .bus_active     (bus_active),
    .bus_error      (bus_error),
    .daisy_out      (daisy_out),
    .debug_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    strobe = 1'b0;
    forever #5 strobe = ~strobe;
  end

  // ---------------- responder at 0x00100..0x001FF ----------------
  logic [3:0]  seed_mem [256];
  logic [3:0]  resp_mem [256];
  logic [19:0] r_pc, r_dp;
  logic [3:0]  r_nib;
  logic        mem_load;
  logic        bus_err_inj;

  function automatic bit claimed(input logic [19:0] a);
    return a[19:8] == 12'h001;
  endfunction

  always @(posedge strobe) begin
    r_nib <= 4'h0;
    if (mem_load) begin
      for (int i = 0; i < 256; i++) resp_mem[i] <= seed_mem[i];
    end
    case (bus_command)
      BUSCMD_LOAD_PC: r_pc <= bus_address;
      BUSCMD_LOAD_DP: r_dp <= bus_address;
      BUSCMD_PC_READ: begin
        if (claimed(r_pc)) r_nib <= resp_mem[r_pc[7:0]];
        r_pc <= r_pc + 20'd1;
      end
      BUSCMD_DP_READ: begin
        if (claimed(r_dp)) r_nib <= resp_mem[r_dp[7:0]];
        r_dp <= r_dp + 20'd1;
      end
      BUSCMD_DP_WRITE: begin
        if (claimed(r_dp)) resp_mem[r_dp[7:0]] <= bus_nibble_out;
        r_dp <= r_dp + 20'd1;
      end
      default: ;
    endcase
  end

  assign bus_nibble_in = r_nib;
  assign bus_active = ((bus_command == BUSCMD_PC_READ) && claimed(r_pc)) ||
                      (((bus_command == BUSCMD_DP_READ) || (bus_command == BUSCMD_DP_WRITE)) && claimed(r_dp));
  assign bus_error = bus_err_inj;

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [63:0] rdata;
    logic [63:0] mask;
    logic [63:0] wdata;
    logic [19:0] addr;
    logic        err;
    logic        is_write;
    logic        chk_addr;
    logic [3:0]  load_cmd;
    logic [3:0]  xfer_cmd;
    int          lat;
    int          n_load;
    int          n_xfer;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  ref_mem [256];
  bit          sh_v [2];
  logic [19:0] sh_a [2];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int resp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit busy = 0;
  int cyc, n_load_seen, n_xfer_seen, n_other;

  always @(negedge strobe) begin
    exp_t e;
    if (reset) begin
      busy = 0;
    end else begin
      if (busy) begin
        cyc++;
        if (exp_q.size() > 0) begin
          if (bus_command == exp_q[0].load_cmd) begin
            n_load_seen++;
            if (exp_q[0].chk_addr) check("load_addr", 64'(bus_address), 64'(exp_q[0].addr));
          end else if (bus_command == exp_q[0].xfer_cmd) begin
            if (exp_q[0].is_write && n_xfer_seen < 16)
              check("write_nibble", 64'(bus_nibble_out), 64'(4'(exp_q[0].wdata >> (4 * n_xfer_seen))));
            n_xfer_seen++;
          end else if (bus_command != BUSCMD_NOP) begin
            n_other++;
          end
        end
      end
      if (resp_valid) begin
        resp_cnt++;
        if (!busy || exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("rdata", resp_rdata & e.mask, e.rdata);
          check("error", 64'(resp_error), 64'(e.err));
          check("latency", 64'(cyc), 64'(e.lat));
          check("load_cycles", 64'(n_load_seen), 64'(e.n_load));
          check("xfer_cycles", 64'(n_xfer_seen), 64'(e.n_xfer));
          check("stray_cmds", 64'(n_other), 64'd0);
          busy = 0;
          done_cnt++;
        end
      end else if (!busy && req_valid && req_ready) begin
        busy = 1;
        cyc = 0;
        n_load_seen = 0;
        n_xfer_seen = 0;
        n_other = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic recover();
    reset = 1'b1;
    @(posedge strobe); #1;
    reset = 1'b0;
    exp_q.delete();
    sh_v[0] = 0;
    sh_v[1] = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [19:0] addr, input logic [3:0] len,
                       input logic [63:0] wdata, input bit inj);
    exp_t e;
    int n, p, t, base_done;
    bit hit;
    logic [19:0] a;
    n = int'(len) + 1;
    e = '0;
    e.mask = '1;
    e.addr = addr;
    e.wdata = wdata;
    if (op == OP_READ_PC || op == OP_READ_DP || op == OP_WRITE_DP) begin
      p = (op == OP_READ_PC) ? 0 : 1;
      hit = CACHE && sh_v[p] && (sh_a[p] == addr);
      e.is_write = (op == OP_WRITE_DP);
      e.load_cmd = (op == OP_READ_PC) ? BUSCMD_LOAD_PC : BUSCMD_LOAD_DP;
      e.xfer_cmd = (op == OP_READ_PC) ? BUSCMD_PC_READ :
                   (op == OP_READ_DP) ? BUSCMD_DP_READ : BUSCMD_DP_WRITE;
      e.chk_addr = 1'b1;
      e.n_load = hit ? 0 : 1;
      e.n_xfer = n;
      e.lat = n + (e.is_write ? 2 : 3) - (hit ? 1 : 0);
      e.err = inj;
      for (int i = 0; i < n; i++) begin
        a = addr + 20'(i);
        if (claimed(a)) begin
          if (e.is_write) ref_mem[a[7:0]] = wdata[4*i +: 4];
          else e.rdata[4*i +: 4] = ref_mem[a[7:0]];
        end else begin
          e.err = 1'b1;
          if (!e.is_write) e.mask[4*i +: 4] = 4'h0;
        end
      end
      sh_a[p] = addr + 20'(n);
      sh_v[p] = 1;
    end else begin
      e.load_cmd = (op == OP_CONFIGURE) ? BUSCMD_CONFIGURE : BUSCMD_RESET;
      e.chk_addr = (op == OP_CONFIGURE);
      e.xfer_cmd = BUSCMD_PC_WRITE;
      e.n_load = 1;
      e.n_xfer = 0;
      e.lat = 2;
      e.err = 1'b0;
      sh_v[0] = 0;
      sh_v[1] = 0;
    end
    exp_q.push_back(e);
    base_done = done_cnt;
    t = 0;
    while (!req_ready && t < 50) begin @(posedge strobe); #1; t++; end
    req_op = op;
    req_addr = addr;
    req_len = len;
    req_wdata = wdata;
    req_valid = 1'b1;
    bus_err_inj = inj;
    @(posedge strobe); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom_range(0, 4));
    req_addr = 20'($urandom);
    req_len = 4'($urandom);
    req_wdata = {$urandom, $urandom};
    t = 0;
    while (done_cnt == base_done && t < 60) begin @(posedge strobe); #1; t++; end
    bus_err_inj = 1'b0;
    if (done_cnt == base_done) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: got no resp_valid in 60 cycles, expected latency %0d", e.lat);
      recover();
    end
  endtask

  task automatic abort_in_xfer();
    int rc;
    rc = resp_cnt;
    req_op = OP_READ_DP;
    req_addr = 20'h00100;
    req_len = 4'd7;
    req_valid = 1'b1;
    @(posedge strobe); #1;           // accept edge; now in LOAD
    req_valid = 1'b0;
    repeat (3) begin @(posedge strobe); #1; end   // XFER cycle index 2
    check("abort_state", 64'(dbg_state), 64'(ST_XFER));
    reset = 1'b1;
    #1;
    check("abort_cmd_nop", 64'(bus_command), 64'(BUSCMD_NOP));
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    check("abort_daisy", 64'(daisy_out), 64'd0);
    @(posedge strobe); #1;
    reset = 1'b0;
    sh_v[0] = 0;
    sh_v[1] = 0;
    repeat (15) @(posedge strobe);
    #1;
    check("abort_no_resp", 64'(resp_cnt - rc), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  op;
    logic [19:0] addr;
    int          r, p;
    reset = 1'b1;
    mem_load = 1'b1;
    req_valid = 1'b0;
    req_op = OP_READ_PC;
    req_addr = '0;
    req_len = '0;
    req_wdata = '0;
    bus_err_inj = 1'b0;
    sh_v[0] = 0;
    sh_v[1] = 0;
    sh_a[0] = '0;
    sh_a[1] = '0;
    for (int i = 0; i < 256; i++) begin
      seed_mem[i] = (i < 4) ? 4'(i + 1) : 4'($urandom);
      ref_mem[i] = seed_mem[i];
    end
    repeat (3) @(posedge strobe);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_error", 64'(resp_error), 64'd0);
    check("rst_bus_command", 64'(bus_command), 64'(BUSCMD_NOP));
    check("rst_bus_address", 64'(bus_address), 64'd0);
    check("rst_bus_nibble_out", 64'(bus_nibble_out), 64'd0);
    check("rst_daisy_out", 64'(daisy_out), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    mem_load = 1'b0;
    reset = 1'b0;
    @(posedge strobe); #1;
    check("daisy_after_reset", 64'(daisy_out), 64'd1);

    issue(OP_CONFIGURE, 20'h00100, 4'd0, 64'd0, 1'b0);
    issue(OP_READ_DP,   20'h00100, 4'd3, 64'd0, 1'b0);
    issue(OP_WRITE_DP,  20'h00105, 4'd0, 64'hA, 1'b0);
    issue(OP_READ_DP,   20'h00105, 4'd0, 64'd0, 1'b0);
    issue(OP_READ_DP,   20'h80000, 4'd3, 64'd0, 1'b0);
    issue(OP_WRITE_DP,  20'h00120, 4'd15, 64'hFEDCBA9876543210, 1'b0);
    issue(OP_READ_DP,   20'h00120, 4'd15, 64'd0, 1'b0);
    issue(OP_READ_PC,   20'h001F8, 4'd15, 64'd0, 1'b0);
    issue(OP_READ_DP,   20'h00140, 4'd2, 64'd0, 1'b1);
    issue(OP_CONFIGURE, 20'h00100, 4'd0, 64'd0, 1'b1);
    issue(OP_BUS_RESET, 20'h00000, 4'd0, 64'd0, 1'b0);
    issue(OP_READ_DP,   20'h00130, 4'd3, 64'd0, 1'b0);
    issue(OP_READ_DP,   20'h00134, 4'd3, 64'd0, 1'b0);
    issue(OP_WRITE_DP,  20'h00138, 4'd1, 64'h5C, 1'b0);
    issue(OP_READ_PC,   20'hFFFFE, 4'd3, 64'd0, 1'b0);
    abort_in_xfer();

    for (int k = 0; k < 50; k++) begin
      r = $urandom_range(0, 9);
      op = (r <= 3) ? OP_READ_DP : (r <= 6) ? OP_WRITE_DP : (r == 7) ? OP_READ_PC :
           (r == 8) ? OP_CONFIGURE : OP_BUS_RESET;
      p = (op == OP_READ_PC) ? 0 : 1;
      r = $urandom_range(0, 9);
      if (r == 0) addr = 20'($urandom);
      else if (r <= 3 && sh_v[p]) addr = sh_a[p];
      else addr = 20'h00100 + 20'($urandom_range(0, 255));
      issue(op, addr, 4'($urandom_range(0, 15)), {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
    end

    repeat (5) @(posedge strobe);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test by t=%0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
